// File: rtl/alu_stream_core.sv
// Streaming ALU: operand select, single-cycle ops, multi-cycle multiply and a
// show-ahead result FIFO with valid/ready backpressure on the output.
module alu_stream_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int MUL_LATENCY = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ACT,
    output logic                      ALU_RDY,
    input  logic [3:0]                OP,
    input  logic [1:0]                MOVI,
    input  logic [DATA_WIDTH-1:0]     REG_A,
    input  logic [DATA_WIDTH-1:0]     REG_B,
    input  logic [DATA_WIDTH-1:0]     MEM,
    input  logic [DATA_WIDTH-1:0]     IMM,
    output logic [2*DATA_WIDTH-1:0]   EX_ALU,
    output logic                      EX_ALU_VLD,
    input  logic                      EX_ALU_RDY
);

    localparam int W        = DATA_WIDTH;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam int MUL_LOAD = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_NOT,
        OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_INC, OP_DEC
    } op_t;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t          state;
    logic [CW-1:0]   mul_cnt;
    logic [2*W-1:0]  mul_q;

    logic [W-1:0]    opnd_b;
    logic [2*W-1:0]  alu_result;
    logic            accept, defer_mul, mul_done, push, pop;
    logic [2*W-1:0]  push_data;

    logic [2*W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     fifo_count;
    logic [2*W-1:0]  last_q;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        opnd_b = REG_B;
        case (MOVI)
            2'd1:    opnd_b = MEM;
            2'd2:    opnd_b = IMM;
            default: opnd_b = REG_B;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (op_t'(OP))
            OP_ADD:  alu_result = {{(W-1){1'b0}}, {1'b0, REG_A} + {1'b0, opnd_b}};
            OP_SUB:  alu_result = {{(W-1){1'b0}}, {1'b0, REG_A} - {1'b0, opnd_b}};
            OP_MUL:  alu_result = {{W{1'b0}}, REG_A} * {{W{1'b0}}, opnd_b};
            OP_SHL:  alu_result = {{W{1'b0}}, REG_A[W-2:0], 1'b0};
            OP_SHR:  alu_result = {{W{1'b0}}, 1'b0, REG_A[W-1:1]};
            OP_ROL:  alu_result = {{W{1'b0}}, REG_A[W-2:0], REG_A[W-1]};
            OP_ROR:  alu_result = {{W{1'b0}}, REG_A[0], REG_A[W-1:1]};
            OP_NOT:  alu_result = {{W{1'b0}}, ~REG_A};
            OP_AND:  alu_result = {{W{1'b0}}, REG_A & opnd_b};
            OP_OR:   alu_result = {{W{1'b0}}, REG_A | opnd_b};
            OP_XOR:  alu_result = {{W{1'b0}}, REG_A ^ opnd_b};
            OP_NAND: alu_result = {{W{1'b0}}, ~(REG_A & opnd_b)};
            OP_NOR:  alu_result = {{W{1'b0}}, ~(REG_A | opnd_b)};
            OP_XNOR: alu_result = {{W{1'b0}}, ~(REG_A ^ opnd_b)};
            OP_INC:  alu_result = {{(W-1){1'b0}}, {1'b0, REG_A} + (W+1)'(1)};
            OP_DEC:  alu_result = {{(W-1){1'b0}}, {1'b0, REG_A} - (W+1)'(1)};
            default: alu_result = '0;
        endcase
    end

    // RST gates ALU_RDY directly so the core refuses work while reset is held.
    assign ALU_RDY    = !RST && (state == IDLE) && (fifo_count < FULL_CNT);
    assign accept     = ACT && ALU_RDY;
    assign defer_mul  = (op_t'(OP) == OP_MUL) && (MUL_LATENCY > 1);
    assign mul_done   = (state == MUL_BUSY) && (mul_cnt == '0);
    assign push       = (accept && !defer_mul) || mul_done;
    assign push_data  = mul_done ? mul_q : alu_result;
    assign pop        = EX_ALU_VLD && EX_ALU_RDY;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            mul_cnt <= '0;
            mul_q   <= '0;
        end else begin
            case (state)
                IDLE: if (accept && defer_mul) begin
                    state   <= MUL_BUSY;
                    mul_cnt <= CW'(MUL_LOAD);
                    mul_q   <= alu_result;
                end
                MUL_BUSY: begin
                    if (mul_cnt == '0) state <= IDLE;
                    else               mul_cnt <= mul_cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage is not reset; occupancy and pointers are, and the
    // output mux never exposes an entry that has not been written.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign EX_ALU_VLD = (fifo_count != '0);
    assign EX_ALU     = EX_ALU_VLD ? fifo_mem[rd_ptr] : last_q;

    push_while_full: assert property (@(posedge CLK) disable iff (RST)
        !(push && (fifo_count == FULL_CNT)));

endmodule

// File: tb/tb_alu_stream_core.sv
// Directed bench for alu_stream_core: ops, operand select, multiply latency,
// backpressure ordering and reset during a multiply.
module tb_alu_stream_core;

    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           ACT = 1'b0;
    logic           ALU_RDY;
    logic [3:0]     OP = '0;
    logic [1:0]     MOVI = '0;
    logic [W-1:0]   REG_A = '0, REG_B = '0, MEM = '0, IMM = '0;
    logic [2*W-1:0] EX_ALU;
    logic           EX_ALU_VLD;
    logic           EX_ALU_RDY = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_stream_core #(.DATA_WIDTH(W), .FIFO_DEPTH(4), .MUL_LATENCY(3)) dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .ALU_RDY(ALU_RDY), .OP(OP), .MOVI(MOVI),
        .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
        .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD), .EX_ALU_RDY(EX_ALU_RDY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] movi, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] i);
        OP = op; MOVI = movi; REG_A = a; REG_B = b; MEM = m; IMM = i; ACT = 1'b1;
    endtask

    typedef struct {
        logic [3:0]     op;
        logic [1:0]     movi;
        logic [W-1:0]   a, b, m, i;
        logic [2*W-1:0] exp;
        string          tag;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int got_n;
        int guard;

        vecs[0]  = '{4'd7,  2'd0, 8'hA5, 8'h3C, 8'h00, 8'h00, 16'h005A, "not"};
        vecs[1]  = '{4'd8,  2'd0, 8'hA5, 8'h3C, 8'h00, 8'h00, 16'h0024, "and"};
        vecs[2]  = '{4'd9,  2'd0, 8'hA5, 8'h3C, 8'h00, 8'h00, 16'h00BD, "or"};
        vecs[3]  = '{4'd10, 2'd0, 8'hA5, 8'h3C, 8'h00, 8'h00, 16'h0099, "xor"};
        vecs[4]  = '{4'd11, 2'd2, 8'hA5, 8'h00, 8'h00, 8'h3C, 16'h00DB, "nand_imm"};
        vecs[5]  = '{4'd12, 2'd1, 8'hA5, 8'h00, 8'h3C, 8'h00, 16'h0042, "nor_mem"};
        vecs[6]  = '{4'd13, 2'd0, 8'hA5, 8'h3C, 8'h00, 8'h00, 16'h0066, "xnor"};
        vecs[7]  = '{4'd14, 2'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h0100, "inc_carry"};
        vecs[8]  = '{4'd15, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h01FF, "dec_borrow"};
        vecs[9]  = '{4'd3,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 16'h0002, "shl"};
        vecs[10] = '{4'd4,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 16'h0040, "shr"};
        vecs[11] = '{4'd6,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 16'h00C0, "ror"};
        vecs[12] = '{4'd0,  2'd3, 8'h10, 8'h20, 8'h77, 8'h55, 16'h0030, "add_movi3"};
        vecs[13] = '{4'd1,  2'd1, 8'h05, 8'h00, 8'h03, 8'h00, 16'h0002, "sub_mem"};

        // Reset state
        repeat (3) tick();
        check("rst_rdy", ALU_RDY, 0);
        check("rst_vld", EX_ALU_VLD, 0);
        check("rst_data", EX_ALU, 0);

        RST = 1'b0;
        EX_ALU_RDY = 1'b1;
        #1;
        check("rdy_after_release", ALU_RDY, 1);

        // ADD with carry
        drive(4'd0, 2'd0, 8'hFF, 8'h01, 8'h00, 8'h00);
        tick();
        ACT = 1'b0;
        check("add_vld", EX_ALU_VLD, 1);
        check("add_data", EX_ALU, 16'h0100);
        tick();
        check("add_drained", EX_ALU_VLD, 0);
        check("add_hold", EX_ALU, 16'h0100);

        // SUB then ROL back to back, in order
        drive(4'd1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h01);
        tick();
        check("sub_data", EX_ALU, 16'h01FF);
        drive(4'd5, 2'd0, 8'h81, 8'h00, 8'h00, 8'h00);
        tick();
        ACT = 1'b0;
        check("rol_vld", EX_ALU_VLD, 1);
        check("rol_data", EX_ALU, 16'h0003);
        tick();
        check("rol_drained", EX_ALU_VLD, 0);

        // Remaining opcodes and operand selects
        foreach (vecs[n]) begin
            drive(vecs[n].op, vecs[n].movi, vecs[n].a, vecs[n].b, vecs[n].m, vecs[n].i);
            tick();
            ACT = 1'b0;
            check(vecs[n].tag, EX_ALU, vecs[n].exp);
            tick();
        end

        // MULT latency 3
        drive(4'd2, 2'd1, 8'hFF, 8'h00, 8'hFF, 8'h00);
        check("mul_rdy_k", ALU_RDY, 1);
        tick();
        ACT = 1'b0;
        check("mul_rdy_k1", ALU_RDY, 0);
        check("mul_vld_k1", EX_ALU_VLD, 0);
        tick();
        check("mul_rdy_k2", ALU_RDY, 0);
        check("mul_vld_k2", EX_ALU_VLD, 0);
        tick();
        check("mul_rdy_k3", ALU_RDY, 1);
        check("mul_vld_k3", EX_ALU_VLD, 1);
        check("mul_data", EX_ALU, 16'hFE01);
        tick();
        check("mul_drained", EX_ALU_VLD, 0);

        // Backpressure: fill the FIFO, then drain with a push during a pop
        EX_ALU_RDY = 1'b0;
        for (int n = 0; n < 4; n++) begin
            drive(4'd0, 2'd0, W'(n), 8'h01, 8'h00, 8'h00);
            check("bp_accept_rdy", ALU_RDY, 1);
            tick();
        end
        REG_A = 8'h04;
        for (int n = 0; n < 3; n++) begin
            check("bp_full_rdy", ALU_RDY, 0);
            check("bp_full_vld", EX_ALU_VLD, 1);
            check("bp_stable", EX_ALU, 16'h0001);
            tick();
        end
        EX_ALU_RDY = 1'b1;
        #1;
        check("bp_pop_no_rdy", ALU_RDY, 0);
        got_n = 0;
        guard = 0;
        while (got_n < 5 && guard < 20) begin
            logic sent;
            sent = ACT && ALU_RDY;
            if (EX_ALU_VLD) begin
                check("bp_order", EX_ALU, 32'(got_n + 1));
                got_n++;
            end
            tick();
            if (sent) ACT = 1'b0;
            guard++;
        end
        check("bp_count", got_n, 5);
        check("bp_no_dup", EX_ALU_VLD, 0);
        check("bp_hold_last", EX_ALU, 16'h0005);

        // Reset in the middle of a MULT
        drive(4'd2, 2'd1, 8'h03, 8'h00, 8'h05, 8'h00);
        tick();
        ACT = 1'b0;
        check("rstmul_busy", ALU_RDY, 0);
        RST = 1'b1;
        #1;
        check("rstmul_vld", EX_ALU_VLD, 0);
        check("rstmul_data", EX_ALU, 0);
        check("rstmul_rdy_in_rst", ALU_RDY, 0);
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rstmul_rdy_release", ALU_RDY, 1);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rstmul_no_product", EX_ALU_VLD, 0);
        end
        check("rstmul_data_zero", EX_ALU, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
